// File: rtl/rob_multi_commit_pkg.sv
// rob_multi_commit_pkg: shared ROB defaults, datapath widths and entry payload type.
package rob_multi_commit_pkg;
  localparam int ADDR_LEN = 32;
  localparam int REG_SEL = 5;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int ROB_DP_W = 2;
  localparam int ROB_COM_W = 2;
  localparam int ROB_CPL_N = 4;
  typedef struct packed {
    logic dst_valid;
    logic [REG_SEL-1:0] dst_arf;
    logic [ADDR_LEN-1:0] pc;
  } rob_entry_t;
  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/rob_multi_commit_commit_select.sv
// rob_commit_select: in-order retire prefix mask, tags and count scanned from head.
module rob_commit_select #(
  parameter int DEPTH = 16,
  parameter int COM_W = 2,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input logic [TAG_W-1:0] head,
  input logic [DEPTH-1:0] valid,
  input logic [DEPTH-1:0] done,
  output logic [COM_W-1:0] mask,
  output logic [COM_W*TAG_W-1:0] tag,
  output logic [$clog2(COM_W+1)-1:0] num
);
  localparam int NW = $clog2(COM_W + 1);
  logic [TAG_W-1:0] idx;
  logic run;
  always_comb begin
    run = 1'b1;
    idx = head;
    mask = '0;
    tag = '0;
    num = '0;
    for (int j = 0; j < COM_W; j++) begin
      idx = head + TAG_W'(j);
      tag[j*TAG_W +: TAG_W] = idx;
      run = run & valid[idx] & done[idx];
      mask[j] = run;
      num = num + NW'(run);
    end
  end
endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: multi-dispatch / multi-commit reorder buffer; optional ROB_FLUSH_EN adds branch squash.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int DP_W = ROB_DP_W,
  parameter int COM_W = ROB_COM_W,
  parameter int CPL_N = ROB_CPL_N,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input logic clk_i,
  input logic reset_i,
`ifdef ROB_FLUSH_EN
  input logic flush_i,
  input logic [TAG_W-1:0] flush_tag_i,
`endif
  input logic [DP_W-1:0] dp_valid_i,
  input logic [DP_W*ADDR_LEN-1:0] dp_pc_i,
  input logic [DP_W-1:0] dp_dst_valid_i,
  input logic [DP_W*REG_SEL-1:0] dp_dst_arf_i,
  output logic dp_ready_o,
  output logic [DP_W*TAG_W-1:0] dp_tag_o,
  input logic [CPL_N-1:0] cpl_valid_i,
  input logic [CPL_N*TAG_W-1:0] cpl_tag_i,
  output logic [COM_W-1:0] com_valid_o,
  output logic [COM_W*TAG_W-1:0] com_tag_o,
  output logic [COM_W-1:0] com_arf_we_o,
  output logic [COM_W*REG_SEL-1:0] com_dst_arf_o,
  output logic [COM_W*ADDR_LEN-1:0] com_pc_o,
  output logic [$clog2(COM_W+1)-1:0] com_num_o,
  output logic [TAG_W:0] free_num_o,
  output logic empty_o,
  output logic full_o
);
  localparam int CW = TAG_W + 1;
  logic [DEPTH-1:0] valid, done;
  rob_entry_t ent [DEPTH];
  logic [TAG_W-1:0] head, tail;
  logic [CW-1:0] count;
  logic dp_fire;
  logic [2:0] dp_num;
  assign free_num_o = CW'(DEPTH) - count;
  assign dp_ready_o = free_num_o >= CW'(DP_W);
  assign empty_o = count == '0;
  assign full_o = count == CW'(DEPTH);
`ifdef ROB_FLUSH_EN
  assign dp_fire = dp_ready_o & ~flush_i;
`else
  assign dp_fire = dp_ready_o;
`endif
  assign dp_num = dp_fire ? pop4(4'(dp_valid_i)) : 3'd0;
  for (genvar k = 0; k < DP_W; k++) begin : g_dp
    assign dp_tag_o[k*TAG_W +: TAG_W] = tail + TAG_W'(k);
  end
  rob_commit_select #(.DEPTH(DEPTH), .COM_W(COM_W), .TAG_W(TAG_W)) u_sel (
    .head(head),
    .valid(valid),
    .done(done),
    .mask(com_valid_o),
    .tag(com_tag_o),
    .num(com_num_o)
  );
  for (genvar j = 0; j < COM_W; j++) begin : g_com
    rob_entry_t e;
    assign e = ent[head + TAG_W'(j)];
    assign com_arf_we_o[j] = com_valid_o[j] & e.dst_valid;
    assign com_dst_arf_o[j*REG_SEL +: REG_SEL] = e.dst_arf;
    assign com_pc_o[j*ADDR_LEN +: ADDR_LEN] = e.pc;
  end
`ifdef ROB_FLUSH_EN
  // An entry is younger than the flush point if it sits past it but still inside the occupied window.
  logic [DEPTH-1:0] young;
  logic [TAG_W-1:0] flush_dist;
  always_comb begin
    flush_dist = flush_tag_i - head;
    young = '0;
    for (int i = 0; i < DEPTH; i++)
      young[i] = (TAG_W'(TAG_W'(i) - head) > flush_dist) && (CW'(TAG_W'(TAG_W'(i) - head)) < count);
  end
`endif
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
      done <= '0;
    end else begin
      for (int p = 0; p < CPL_N; p++)
        if (cpl_valid_i[p] && valid[cpl_tag_i[p*TAG_W +: TAG_W]]) done[cpl_tag_i[p*TAG_W +: TAG_W]] <= 1'b1;
      for (int k = 0; k < DP_W; k++)
        if (dp_fire && dp_valid_i[k]) begin
          valid[tail + TAG_W'(k)] <= 1'b1;
          done[tail + TAG_W'(k)] <= 1'b0;
        end
      for (int j = 0; j < COM_W; j++)
        if (com_valid_o[j]) begin
          valid[head + TAG_W'(j)] <= 1'b0;
          done[head + TAG_W'(j)] <= 1'b0;
        end
      head <= head + TAG_W'(com_num_o);
`ifdef ROB_FLUSH_EN
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++)
          if (young[i]) begin
            valid[i] <= 1'b0;
            done[i] <= 1'b0;
          end
        tail <= flush_tag_i + 1'b1;
        count <= CW'(flush_dist) + CW'(1) - CW'(com_num_o);
      end else
`endif
      begin
        tail <= tail + TAG_W'(dp_num);
        count <= count + CW'(dp_num) - CW'(com_num_o);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DP_W; k++)
      if (dp_fire && dp_valid_i[k])
        ent[tail + TAG_W'(k)] <= '{dst_valid: dp_dst_valid_i[k], dst_arf: dp_dst_arf_i[k*REG_SEL +: REG_SEL], pc: dp_pc_i[k*ADDR_LEN +: ADDR_LEN]};
  end
endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: directed checks of dispatch, completion, commit, full/wrap and optional flush.
module tb_rob_multi_commit;
  import rob_multi_commit_pkg::*;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic flush_i = 1'b0;
  logic [2:0] flush_tag_i = '0;
  logic [1:0] dp_valid_i = '0;
  logic [2*ADDR_LEN-1:0] dp_pc_i = '0;
  logic [1:0] dp_dst_valid_i = '0;
  logic [2*REG_SEL-1:0] dp_dst_arf_i = '0;
  logic dp_ready_o;
  logic [5:0] dp_tag_o;
  logic [3:0] cpl_valid_i = '0;
  logic [11:0] cpl_tag_i = '0;
  logic [1:0] com_valid_o;
  logic [5:0] com_tag_o;
  logic [1:0] com_arf_we_o;
  logic [2*REG_SEL-1:0] com_dst_arf_o;
  logic [2*ADDR_LEN-1:0] com_pc_o;
  logic [1:0] com_num_o;
  logic [3:0] free_num_o;
  logic empty_o, full_o;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  rob_multi_commit #(.DEPTH(8), .DP_W(2), .COM_W(2), .CPL_N(4)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
`ifdef ROB_FLUSH_EN
    .flush_i(flush_i),
    .flush_tag_i(flush_tag_i),
`endif
    .dp_valid_i(dp_valid_i),
    .dp_pc_i(dp_pc_i),
    .dp_dst_valid_i(dp_dst_valid_i),
    .dp_dst_arf_i(dp_dst_arf_i),
    .dp_ready_o(dp_ready_o),
    .dp_tag_o(dp_tag_o),
    .cpl_valid_i(cpl_valid_i),
    .cpl_tag_i(cpl_tag_i),
    .com_valid_o(com_valid_o),
    .com_tag_o(com_tag_o),
    .com_arf_we_o(com_arf_we_o),
    .com_dst_arf_o(com_dst_arf_o),
    .com_pc_o(com_pc_o),
    .com_num_o(com_num_o),
    .free_num_o(free_num_o),
    .empty_o(empty_o),
    .full_o(full_o)
  );
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic disp(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1, input logic [4:0] r0, input logic [4:0] r1);
    dp_valid_i = v;
    dp_pc_i = {pc1, pc0};
    dp_dst_valid_i = v;
    dp_dst_arf_i = {r1, r0};
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    dp_valid_i = '0;
    cpl_valid_i = '0;
    flush_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask
  initial begin
    tick();
    do_reset();
    check("rst_com_valid", 64'(com_valid_o), 64'd0);
    check("rst_com_num", 64'(com_num_o), 64'd0);
    check("rst_free", 64'(free_num_o), 64'd8);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_ready", 64'(dp_ready_o), 64'd1);
    disp(2'b11, 32'h100, 32'h104, 5'd5, 5'd6);
    #1;
    check("t1_dp_tag", 64'(dp_tag_o), 64'({3'd1, 3'd0}));
    tick();
    dp_valid_i = '0;
    check("t1_free", 64'(free_num_o), 64'd6);
    check("t1_no_commit", 64'(com_valid_o), 64'd0);
    cpl_valid_i = 4'b0001;
    cpl_tag_i = {9'd0, 3'd1};
    tick();
    cpl_valid_i = '0;
    check("t2_no_commit_tag1", 64'(com_valid_o), 64'd0);
    cpl_valid_i = 4'b0001;
    cpl_tag_i = {9'd0, 3'd0};
    tick();
    cpl_valid_i = '0;
    check("t2_com_num", 64'(com_num_o), 64'd2);
    check("t2_com_valid", 64'(com_valid_o), 64'b11);
    check("t2_arf_we", 64'(com_arf_we_o), 64'b11);
    check("t2_dst", 64'(com_dst_arf_o), 64'({5'd6, 5'd5}));
    check("t2_pc", com_pc_o, {32'h104, 32'h100});
    check("t2_tag", 64'(com_tag_o), 64'({3'd1, 3'd0}));
    tick();
    check("t2_empty_after", 64'(empty_o), 64'd1);
    check("t2_free_after", 64'(free_num_o), 64'd8);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      disp(2'b11, 32'h10 + 32'(c * 8), 32'h14 + 32'(c * 8), 5'(c), 5'(c + 8));
      tick();
    end
    check("t3_full", 64'(full_o), 64'd1);
    check("t3_ready", 64'(dp_ready_o), 64'd0);
    check("t3_free", 64'(free_num_o), 64'd0);
    tick();
    dp_valid_i = '0;
    check("t3_full_hold", 64'(full_o), 64'd1);
    check("t3_tail_hold", 64'(dp_tag_o), 64'({3'd1, 3'd0}));
    cpl_valid_i = 4'b0011;
    cpl_tag_i = {6'd0, 3'd1, 3'd0};
    tick();
    cpl_valid_i = '0;
    disp(2'b11, 32'h200, 32'h204, 5'd7, 5'd8);
    #1;
    check("t4_commit_visible", 64'(com_num_o), 64'd2);
    check("t4_ready_blocked", 64'(dp_ready_o), 64'd0);
    tick();
    check("t4_free_after_commit", 64'(free_num_o), 64'd2);
    check("t4_ready_again", 64'(dp_ready_o), 64'd1);
    check("t4_wrap_tag", 64'(dp_tag_o), 64'({3'd1, 3'd0}));
    tick();
    dp_valid_i = '0;
    check("t4_full_again", 64'(full_o), 64'd1);
    check("t4_tail_after", 64'(dp_tag_o), 64'({3'd3, 3'd2}));
    do_reset();
    disp(2'b11, 32'h300, 32'h304, 5'd1, 5'd2);
    tick();
    disp(2'b11, 32'h308, 32'h30c, 5'd3, 5'd4);
    tick();
    dp_valid_i = '0;
    cpl_valid_i = 4'b0111;
    cpl_tag_i = {3'd0, 3'd6, 3'd3, 3'd3};
    tick();
    cpl_valid_i = '0;
    check("t5_no_spurious", 64'(com_valid_o), 64'd0);
    check("t5_free", 64'(free_num_o), 64'd4);
    cpl_valid_i = 4'b0111;
    cpl_tag_i = {3'd0, 3'd2, 3'd1, 3'd0};
    tick();
    cpl_valid_i = '0;
    check("t5_commit01", 64'(com_tag_o), 64'({3'd1, 3'd0}));
    tick();
    check("t5_commit23", 64'(com_num_o), 64'd2);
    check("t5_pc23", com_pc_o, {32'h30c, 32'h308});
    tick();
    check("t5_empty", 64'(empty_o), 64'd1);
    disp(2'b11, 32'h400, 32'h404, 5'd9, 5'd10);
    tick();
    disp(2'b11, 32'h408, 32'h40c, 5'd11, 5'd12);
    tick();
    dp_valid_i = '0;
    cpl_valid_i = 4'b0011;
    cpl_tag_i = {6'd0, 3'd5, 3'd4};
    tick();
    cpl_valid_i = '0;
    check("t5_commit45", 64'(com_num_o), 64'd2);
    tick();
    check("t5_tag6_not_done", 64'(com_valid_o), 64'd0);
`ifdef ROB_FLUSH_EN
    do_reset();
    for (int c = 0; c < 3; c++) begin
      disp(2'b11, 32'h500 + 32'(c * 8), 32'h504 + 32'(c * 8), 5'(c), 5'(c + 3));
      tick();
    end
    dp_valid_i = '0;
    flush_i = 1'b1;
    flush_tag_i = 3'd2;
    tick();
    flush_i = 1'b0;
    check("t6_free", 64'(free_num_o), 64'd5);
    check("t6_next_tags", 64'(dp_tag_o), 64'({3'd4, 3'd3}));
    cpl_valid_i = 4'b1111;
    cpl_tag_i = {3'd3, 3'd2, 3'd1, 3'd0};
    tick();
    cpl_valid_i = 4'b0011;
    cpl_tag_i = {6'd0, 3'd5, 3'd4};
    check("t6_commit01", 64'(com_num_o), 64'd2);
    tick();
    cpl_valid_i = '0;
    check("t6_commit2_num", 64'(com_num_o), 64'd1);
    check("t6_commit2_tag", 64'(com_tag_o[2:0]), 64'd2);
    tick();
    check("t6_no_squashed", 64'(com_valid_o), 64'd0);
    check("t6_empty", 64'(empty_o), 64'd1);
    check("t6_dp_tags", 64'(dp_tag_o), 64'({3'd4, 3'd3}));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer; successor to the single-instruction ROB in the COM stage.
- Allocates up to DP_W entries per cycle in program order at dispatch.
- Marks entries done from CPL_N execution-unit completion ports.
- Retires up to COM_W consecutive completed entries per cycle from the head, driving ARF write-back and the RRF free count in ReNameUnit.

Parameters:
- DEPTH, 16, number of ROB entries; must be a power of two, >= 4.
- DP_W, 2, dispatch lanes per cycle, 1..4.
- COM_W, 2, commit lanes per cycle, 1..4.
- CPL_N, 4, completion ports (ALU, ALU2, branch, ldst).
- TAG_W, $clog2(DEPTH), entry tag width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- dp_valid_i  in  DP_W  per-lane dispatch request; lanes must be contiguous from lane 0.
- dp_pc_i  in  DP_W*ADDR_LEN  PC per lane.
- dp_dst_valid_i  in  DP_W  lane writes an architectural register.
- dp_dst_arf_i  in  DP_W*REG_SEL  destination ARF index per lane.
- dp_ready_o  out  1  free entries >= DP_W.
- dp_tag_o  out  DP_W*TAG_W  tags allocated to lanes this cycle (tail+lane).
- cpl_valid_i  in  CPL_N  completion strobe per port.
- cpl_tag_i  in  CPL_N*TAG_W  completing entry tag per port.
- com_valid_o  out  COM_W  lane retires this cycle.
- com_tag_o  out  COM_W*TAG_W  retired tag, which equals the RRF tag to release.
- com_arf_we_o  out  COM_W  retired entry writes ARF (com_valid & dst_valid).
- com_dst_arf_o  out  COM_W*REG_SEL  ARF index.
- com_pc_o  out  COM_W*ADDR_LEN  retired PC.
- com_num_o  out  $clog2(COM_W+1)  popcount of com_valid_o.
- free_num_o  out  TAG_W+1  free entries.
- empty_o  out  1  count == 0.
- full_o  out  1  count == DEPTH.

Behaviour:
- State:
  - Per-entry valid, done, dst_valid, dst_arf, pc.
  - head and tail pointers, each TAG_W bits.
  - count register, TAG_W+1 bits.
- Reset:
  - head = tail = count = 0; all valid/done bits = 0.
  - Outputs after reset: com_valid_o = 0, com_num_o = 0, free_num_o = DEPTH, empty_o = 1, full_o = 0, dp_ready_o = 1.
  - Reset asserted mid-operation discards all entries in the same edge.
- Dispatch:
  - Accepted at the clock edge when dp_ready_o & dp_valid_i[k].
  - Entry tail+k is written with valid = 1, done = 0.
  - tail advances by popcount(dp_valid_i) modulo DEPTH, wrapping naturally.
  - dp_tag_o is combinational from tail.
  - If dp_ready_o = 0, all lanes are dropped and the upstream stage must stall.
  - Non-contiguous dp_valid_i is illegal; behaviour is undefined.
- Completion:
  - At the edge, done[cpl_tag_i[p]] is set for each cpl_valid_i[p].
  - Multiple ports hitting the same tag OR together.
  - Completion to an entry with valid = 0 is ignored.
  - Done bits are registered, so a completion in cycle t is first committable in t+1.
- Commit:
  - Combinational scan from head.
  - Lane j is valid iff every lane i <= j has valid & done at entry head+i, with wrap handled modulo DEPTH.
  - The scan stops at the first not-done entry, so com_valid_o is always a prefix mask.
  - At the edge, retired entries clear valid/done and head advances by com_num_o.
- Count and flags:
  - count_next = count + dispatched - com_num_o.
  - Simultaneous dispatch and commit are legal.
  - Entries freed in cycle t become allocatable in t+1, because free_num_o and dp_ready_o derive from the registered count.
  - DEPTH entries in flight gives full_o = 1 and dp_ready_o = 0.
  - Empty ROB gives com_valid_o = 0.
- Latency: dispatch to earliest commit is 2 edges (dispatch edge, completion edge, then commit visible on the following cycle).

Optional Feature:
- ROB_FLUSH_EN adds two inputs: flush_i (1) and flush_tag_i (TAG_W), the tag of the mispredicting branch.
- With flush_i asserted:
  - All entries strictly younger than flush_tag_i (from flush_tag_i+1 up to tail-1) are invalidated.
  - tail = flush_tag_i + 1.
  - count is recomputed as the distance from head to the new tail.
  - Dispatch is dropped that cycle.
  - Commit of entries older than or equal to flush_tag_i still proceeds.
- Without the macro: no flush ports, no squash logic, and the pointers are only moved by dispatch and commit.

Decomposition:
- Shared package/header (extends consts/Consts.vh): ROB_DEPTH, ROB_TAG_W, ROB_DP_W, ROB_COM_W, ROB_CPL_N defaults, plus the ROB entry field widths.
- One sub-module, rob_commit_select: given head plus the valid and done vectors, produces the COM_W prefix mask, the tags and com_num.
- The prefix mask is purely combinational and reusable for a later load/store queue.

Test Plan:
All scenarios use DEPTH=8, DP_W=2, COM_W=2, CPL_N=4.
1. Reset, then dispatch 2 lanes (pc 0x100/0x104, rd 5/6) -> dp_tag_o = {1,0}; free_num_o = 6 next cycle; no commit.
2. Complete tag 1 only, then tag 0 a cycle later -> no commit after tag 1; commit of both (com_num_o = 2, arf_we, dst 5,6) in the cycle after tag 0 completes.
3. Fill 8 entries over 4 cycles -> full_o = 1, dp_ready_o = 0; the 5th dispatch is ignored and tail is unchanged.
4. With count = 8, complete tags 0,1, then dispatch 2 in the commit cycle -> the dispatch is rejected; the next cycle accepts it with tags 0,1 (wrap-around).
5. Two ports complete tag 3 in the same cycle, and port 2 completes invalid tag 6 -> tag 3 done once; tag 6 remains invalid; no spurious commit.
6. (ROB_FLUSH_EN) 6 in flight (tags 0-5), flush_i with tag 2 -> tail = 3, count = 3, tags 3-5 never commit, next dispatch receives tags 3,4.
